phoenix_input_buffer: RTL

Per-port input FIFO of the Phoenix router, directly upstream of `switchcontrol`. It stores incoming flits under credit-based flow control and requests routing for each packet header via `h`/`ack_h`. Once routed, it streams header, size and payload flits to the crossbar, raising `sender` for the packet's lifetime so the switch control can free the output port when `sender` falls. One instance per port; each instance's `h`, `sender` and `data` bits feed the corresponding `switchcontrol` vectors.

---
 rtl/phoenix_input_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/phoenix_input_buffer.sv
// Phoenix router per-port input buffer.
// Circular FIFO with credit-based flow control. A header at the FIFO head
// raises a routing request (h/ack_h). Once granted, the header, size and
// payload flits stream out to the crossbar while sender is held high.
module phoenix_input_buffer #(
  parameter int TAM_FLIT   = 16,
  parameter int TAM_BUFFER = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rx,
  input  logic [TAM_FLIT-1:0] data_in,
  output logic                credit_o,
  output logic                h,
  input  logic                ack_h,
  output logic                data_av,
  output logic [TAM_FLIT-1:0] data,
  input  logic                data_ack,
  output logic                sender
);

  localparam int AW = $clog2(TAM_BUFFER);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(TAM_BUFFER);
  localparam logic [AW:0] ONE_COUNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);
  localparam logic [TAM_FLIT-1:0] ONE_FLIT = TAM_FLIT'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2} state_t;
  typedef enum logic [1:0] {HDR = 2'd0, SIZE = 2'd1, PAY = 2'd2} phase_t;

  logic [TAM_FLIT-1:0] mem [TAM_BUFFER];
  logic [AW-1:0]       first;
  logic [AW-1:0]       last;
  logic [AW:0]         count;
  logic [TAM_FLIT-1:0] remaining;
  state_t              state;
  phase_t              phase;
  logic                push;
  logic                pop;

  // Flow control and head-of-FIFO outputs are pure decodes of stored state.
  assign credit_o = (count != FULL_COUNT);
  assign data_av  = (state == SEND) && (count != '0);
  assign data     = mem[first];
  assign push     = rx & credit_o;
  assign pop      = data_av & data_ack;

  // Storage array: written on accepted flits only, never cleared by reset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[last] <= data_in;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the buffer depth.
  always_ff @(posedge clock) begin
    if (!reset) begin
      first <= '0;
      last  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        last <= last + ONE_PTR;
      end else begin
        last <= last;
      end
      if (pop) begin
        first <= first + ONE_PTR;
      end else begin
        first <= first;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // Packet FSM: request routing, then track header/size/payload until the last pop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= HDR;
      remaining <= '0;
      h         <= 1'b0;
      sender    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= REQ;
            h     <= 1'b1;
          end
        end
        REQ: begin
          if (ack_h) begin
            state  <= SEND;
            h      <= 1'b0;
            sender <= 1'b1;
            phase  <= HDR;
          end
        end
        SEND: begin
          if (pop) begin
            case (phase)
              HDR: begin
                phase <= SIZE;
              end
              SIZE: begin
                remaining <= data;
                phase     <= PAY;
                if (data == '0) begin
                  sender <= 1'b0;
                  state  <= IDLE;
                end
              end
              PAY: begin
                remaining <= remaining - ONE_FLIT;
                if (remaining == ONE_FLIT) begin
                  sender <= 1'b0;
                  state  <= IDLE;
                end
              end
              default: begin
                phase <= HDR;
              end
            endcase
          end
        end
        default: begin
          state  <= IDLE;
          h      <= 1'b0;
          sender <= 1'b0;
        end
      endcase
    end
  end

endmodule
